// File: rtl/tmds_align_lock.sv
// -----------------------------------------------------------------------------
// tmds_align_lock
//
// Word-alignment and lock controller for the TMDS receive path. It sits behind
// the 1:10 deserialisers and serves every data channel from the pixel clock.
// Each channel looks for the four TMDS control tokens. While a channel has not
// seen a long enough run of tokens, it requests ISERDES bitslips. After a run of
// LOCK_COUNT consecutive tokens, the channel holds lock. It drops back to search
// once tokens have been absent for LOSS_WINDOW cycles.
//
// Ports
//   clk_1x_in    in   1          pixel-rate clock
//   rst_n_in     in   1          asynchronous active-low reset
//   deser_data   in   10*NUM_CH  deserialised words, channel c = [10c+9:10c]
//   is_tmds      out  NUM_CH     registered control-token hit per channel
//   token_id     out  2*NUM_CH   index of the last token seen (held on misses)
//   bitslip      out  NUM_CH     single-cycle bitslip request per channel
//   ch_aligned   out  NUM_CH     channel is in LOCKED
//   all_aligned  out  1          registered AND of ch_aligned
//   slip_cnt     out  4*NUM_CH   bitslips since the last lock, saturating at 15
// -----------------------------------------------------------------------------
module tmds_align_lock #(
  parameter int NUM_CH        = 3,
  parameter int SEARCH_WINDOW = 4096,
  parameter int LOCK_COUNT    = 8,
  parameter int BITSLIP_WAIT  = 16,
  parameter int LOSS_WINDOW   = 65536
) (
  input  logic                  clk_1x_in,
  input  logic                  rst_n_in,
  input  logic [10*NUM_CH-1:0]  deser_data,
  output logic [NUM_CH-1:0]     is_tmds,
  output logic [2*NUM_CH-1:0]   token_id,
  output logic [NUM_CH-1:0]     bitslip,
  output logic [NUM_CH-1:0]     ch_aligned,
  output logic                  all_aligned,
  output logic [4*NUM_CH-1:0]   slip_cnt
);

  // Counters are only as wide as needed to hold limit-1. Each FSM leaves its
  // state when a counter reaches its last value, so no counter ever wraps.
  localparam int WIN_W  = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int RUN_W  = (LOCK_COUNT    > 1) ? $clog2(LOCK_COUNT)    : 1;
  localparam int WAIT_W = (BITSLIP_WAIT  > 1) ? $clog2(BITSLIP_WAIT)  : 1;
  localparam int LOSS_W = (LOSS_WINDOW   > 1) ? $clog2(LOSS_WINDOW)   : 1;

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BITSLIP_WAIT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WINDOW - 1);

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  logic all_aligned_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [9:0]        word;
    logic              hit_d;
    logic [1:0]        tok_d;
    logic              hit_q;
    logic [1:0]        tok_q;
    state_t            state_q;
    logic [WIN_W-1:0]  win_q;
    logic [RUN_W-1:0]  run_q;
    logic [WAIT_W-1:0] wait_q;
    logic [LOSS_W-1:0] loss_q;
    logic [3:0]        slip_q;
    logic              bitslip_q;
    logic              aligned_q;

    assign word = deser_data[10*c +: 10];

    // Token decode; the index is held on non-token words.
    always_comb begin
      hit_d = 1'b1;
      tok_d = tok_q;
      case (word)
        TOK0:    tok_d = 2'd0;
        TOK1:    tok_d = 2'd1;
        TOK2:    tok_d = 2'd2;
        TOK3:    tok_d = 2'd3;
        default: hit_d = 1'b0;
      endcase
    end

    always_ff @(posedge clk_1x_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        hit_q <= 1'b0;
        tok_q <= 2'd0;
      end else begin
        hit_q <= hit_d;
        tok_q <= tok_d;
      end
    end

    // Alignment FSM. It runs on the registered hit. Outputs are registered
    // alongside the state, so bitslip is high exactly while in SLIP and
    // ch_aligned is high exactly while in LOCKED.
    always_ff @(posedge clk_1x_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        state_q   <= ST_SEARCH;
        win_q     <= '0;
        run_q     <= '0;
        wait_q    <= '0;
        loss_q    <= '0;
        slip_q    <= 4'd0;
        bitslip_q <= 1'b0;
        aligned_q <= 1'b0;
      end else begin
        bitslip_q <= 1'b0;
        case (state_q)
          ST_SEARCH: begin
            win_q <= win_q + 1'b1;
            run_q <= hit_q ? run_q + 1'b1 : '0;
            // This hit completes the run. Lock takes priority over window expiry.
            if (hit_q && (run_q == RUN_LAST)) begin
              state_q   <= ST_LOCKED;
              aligned_q <= 1'b1;
              loss_q    <= '0;
              slip_q    <= 4'd0;
              win_q     <= '0;
              run_q     <= '0;
            end else if (win_q == WIN_LAST) begin
              state_q   <= ST_SLIP;
              bitslip_q <= 1'b1;
              win_q     <= '0;
              run_q     <= '0;
              if (slip_q != 4'hF) slip_q <= slip_q + 4'd1;
            end
          end
          ST_SLIP: begin
            state_q <= ST_WAIT;
            wait_q  <= '0;
          end
          ST_WAIT: begin
            // Hits are ignored while the deserialiser settles after a slip.
            if (wait_q == WAIT_LAST) begin
              state_q <= ST_SEARCH;
              win_q   <= '0;
              run_q   <= '0;
            end else begin
              wait_q <= wait_q + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (hit_q) begin
              loss_q <= '0;
            end else if (loss_q == LOSS_LAST) begin
              state_q   <= ST_SEARCH;
              aligned_q <= 1'b0;
              win_q     <= '0;
              run_q     <= '0;
            end else begin
              loss_q <= loss_q + 1'b1;
            end
          end
          default: begin
            state_q <= ST_SEARCH;
          end
        endcase
      end
    end

    assign is_tmds[c]         = hit_q;
    assign token_id[2*c +: 2] = tok_q;
    assign bitslip[c]         = bitslip_q;
    assign ch_aligned[c]      = aligned_q;
    assign slip_cnt[4*c +: 4] = slip_q;
  end

  always_ff @(posedge clk_1x_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      all_aligned_q <= 1'b0;
    end else begin
      all_aligned_q <= &ch_aligned;
    end
  end

  assign all_aligned = all_aligned_q;

endmodule

// File: tb/tb_tmds_align_lock.sv
module tb_tmds_align_lock;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [29:0] data = '0;
  logic [2:0]  is_tmds;
  logic [5:0]  token_id;
  logic [2:0]  bitslip;
  logic [2:0]  ch_aligned;
  logic        all_aligned;
  logic [11:0] slip_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tmds_align_lock #(
    .NUM_CH       (3),
    .SEARCH_WINDOW(64),
    .LOCK_COUNT   (8),
    .BITSLIP_WAIT (4),
    .LOSS_WINDOW  (32)
  ) dut (
    .clk_1x_in  (clk),
    .rst_n_in   (rst_n),
    .deser_data (data),
    .is_tmds    (is_tmds),
    .token_id   (token_id),
    .bitslip    (bitslip),
    .ch_aligned (ch_aligned),
    .all_aligned(all_aligned),
    .slip_cnt   (slip_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_is_tmds"},  32'(is_tmds),     32'd0);
    check({tag, "_token_id"}, 32'(token_id),    32'd0);
    check({tag, "_bitslip"},  32'(bitslip),     32'd0);
    check({tag, "_aligned"},  32'(ch_aligned),  32'd0);
    check({tag, "_all"},      32'(all_aligned), 32'd0);
    check({tag, "_slipcnt"},  32'(slip_cnt),    32'd0);
  endtask

  // Reset is released 1 time unit after an edge. Edge 1 is the next posedge.
  task automatic apply_reset();
    rst_n = 1'b0;
    data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_token(input logic [9:0] w);
    return (w == T0) || (w == T1) || (w == T2) || (w == T3);
  endfunction

  initial begin
    int p;
    int s;
    logic [9:0] w;
    #2;

    // Phase A: 8 tokens on ch0 lock it without any slip.
    apply_reset();
    check("A_pre_hit", 32'(is_tmds), 32'd0);
    for (int e = 1; e <= 20; e++) begin
      data[9:0] = (e <= 8) ? T0 : 10'h000;
      step();
      if (e == 1) check("A_hit_lat1", 32'(is_tmds), 32'b001);
      if (e == 1) check("A_tokid", 32'(token_id[1:0]), 32'd0);
      if (e == 8) check("A_not_yet_locked", 32'(ch_aligned), 32'b000);
      if (e == 9) check("A_locked", 32'(ch_aligned), 32'b001);
      if (e == 9) check("A_hit_gone", 32'(is_tmds[0]), 32'd0);
      check("A_no_slip_ch0", 32'(bitslip[0]), 32'd0);
    end

    // Phase B: non-token data slips every 69 cycles. slip_cnt saturates at 15.
    apply_reset();
    for (int e = 1; e <= 1200; e++) begin
      w = 10'($urandom);
      if (is_token(w)) w = 10'h000;
      data = {10'h000, w, 10'h000};
      step();
      p = (e >= 64) ? ((e - 64) / 69 + 1) : 0;
      s = (p > 15) ? 15 : p;
      check("B_bitslip", 32'(bitslip),
            (e >= 64 && ((e - 64) % 69) == 0) ? 32'b111 : 32'b000);
      check("B_slip_cnt1", 32'(slip_cnt[7:4]), 32'(s));
      if (e == 1200) check("B_no_lock", 32'(ch_aligned), 32'd0);
    end

    // Phase C: 7 tokens, 1 miss, 8 tokens on ch2. Lock comes only after the second run.
    apply_reset();
    for (int e = 1; e <= 20; e++) begin
      data[29:20] = ((e >= 1 && e <= 7) || (e >= 9 && e <= 16)) ? T2 : 10'h000;
      step();
      if (e >= 9 && e <= 16) check("C_no_early_lock", 32'(ch_aligned[2]), 32'd0);
      if (e == 17) check("C_lock", 32'(ch_aligned[2]), 32'd1);
      if (e == 20) check("C_tokid_hold", 32'(token_id[5:4]), 32'd2);
    end

    // Phase D: all channels lock, then ch0 loses tokens and drops out.
    apply_reset();
    for (int e = 1; e <= 110; e++) begin
      data = {T3, T1, (e <= 12) ? T2 : 10'h000};
      step();
      if (e == 8)  check("D_not_locked", 32'(ch_aligned), 32'b000);
      if (e == 9)  check("D_all_ch", 32'(ch_aligned), 32'b111);
      if (e == 9)  check("D_all_lag", 32'(all_aligned), 32'd0);
      if (e == 10) check("D_all_up", 32'(all_aligned), 32'd1);
      if (e == 10) check("D_tokids", 32'(token_id), 32'b110110);
      if (e == 44) check("D_still_locked", 32'(ch_aligned), 32'b111);
      if (e == 45) check("D_ch0_drop", 32'(ch_aligned), 32'b110);
      if (e == 45) check("D_all_lag_fall", 32'(all_aligned), 32'd1);
      if (e == 46) check("D_all_fall", 32'(all_aligned), 32'd0);
      if (e == 50) check("D_tokid_hold", 32'(token_id[1:0]), 32'd2);
      if (e == 108) check("D_no_slip_yet", 32'(bitslip), 32'b000);
      if (e == 109) check("D_search_slip", 32'(bitslip), 32'b001);
      if (e == 109) check("D_slip_cnt0", 32'(slip_cnt[3:0]), 32'd1);
    end

    // Phase E: the run completes on the window-expiry cycle, and lock wins.
    apply_reset();
    for (int e = 1; e <= 66; e++) begin
      data[9:0] = (e >= 56 && e <= 63) ? T1 : 10'h000;
      step();
      if (e == 63) check("E_pre_lock", 32'(ch_aligned), 32'b000);
      if (e == 64) check("E_lock", 32'(ch_aligned), 32'b001);
      if (e == 64) check("E_slip_others", 32'(bitslip), 32'b110);
      if (e == 64) check("E_slip_cnt", 32'(slip_cnt), 32'h110);
      if (e == 65) check("E_no_slip_after", 32'(bitslip), 32'b000);
    end

    // Phase F: async reset asserted during SLIP clears everything at once.
    apply_reset();
    for (int e = 1; e <= 64; e++) begin
      data = {10'h000, 10'h000, T3};
      step();
    end
    check("F_in_slip", 32'(bitslip), 32'b110);
    check("F_pre_tokid", 32'(token_id), 32'b000011);
    check("F_pre_aligned", 32'(ch_aligned), 32'b001);
    rst_n = 1'b0;
    #1;
    check_all_zero("F_async");
    repeat (2) @(posedge clk);
    #1;
    check("F_held_bitslip", 32'(bitslip), 32'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 64; e++) begin
      step();
      if (e == 1)  check("F_hit_again", 32'(is_tmds), 32'b001);
      if (e == 9)  check("F_relock", 32'(ch_aligned), 32'b001);
      if (e == 63) check("F_no_slip", 32'(bitslip), 32'b000);
      if (e == 64) check("F_slip_again", 32'(bitslip), 32'b110);
      if (e == 64) check("F_slip_cnt", 32'(slip_cnt), 32'h110);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
